// File: rtl/pulse_stretcher.sv
// pulse_stretcher
//   Turns short internal events (single-cycle strobes, trap flags, byte strobes) into
//   human-visible LED pulses. Each rising edge on inp produces one out pulse of exactly
//   hold_cycles cycles, followed by at least gap_cycles low cycles, so back-to-back
//   events stay distinguishable on the LED.
//
// Parameters
//   hold_cycles : cycles out stays high per event (>= 1)
//   gap_cycles  : minimum low cycles after each pulse (>= 1)
//   pend_width  : width of the pending-event counter (saturates at 2**pend_width-1)
//
// Ports
//   clk     : clock, all logic on posedge
//   rst     : asynchronous active-high reset
//   inp     : event source, an event is a rising edge
//   out     : stretched pulse (registered)
//   busy    : high whenever the stretcher is not idle (registered)
//   pending : queued events not yet shown (tied to 0 without queueing)
//
// Build option
//   STRETCH_QUEUE_EN : when defined, events arriving during a pulse or its gap are
//   counted and replayed as full pulses. When undefined, an event during the high
//   phase restarts the high phase and an event during the gap is dropped.

module pulse_stretcher #(
  parameter int unsigned hold_cycles = 1000,
  parameter int unsigned gap_cycles  = 1000,
  parameter int unsigned pend_width  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inp,
  output logic                  out,
  output logic                  busy,
  output logic [pend_width-1:0] pending
);

  localparam int unsigned MaxCycles = (hold_cycles > gap_cycles) ? hold_cycles : gap_cycles;
  localparam int unsigned CntW      = $clog2(MaxCycles) + 1;

  localparam logic [CntW-1:0] HoldLast = CntW'(hold_cycles - 1);
  localparam logic [CntW-1:0] GapLast  = CntW'(gap_cycles - 1);

  typedef enum logic [1:0] {
    StIdle,
    StHold,
    StGap
  } state_e;

  state_e          r_state;
  logic [CntW-1:0] r_count;
  logic            r_inp_q;
  logic            r_out;
  logic            r_busy;
  logic            w_ev;

  // A level held high counts once: only the low-to-high transition is an event.
  assign w_ev = inp & ~r_inp_q;

`ifdef STRETCH_QUEUE_EN
  logic [pend_width-1:0] r_pending;
  logic                  w_pend_full;

  assign w_pend_full = &r_pending;
  assign pending     = r_pending;
`else
  assign pending     = '0;
`endif

  // out/busy are loaded together with the next state, so they are glitch-free
  // registered decodes of the state that is current in the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_count   <= '0;
      r_inp_q   <= 1'b0;
      r_out     <= 1'b0;
      r_busy    <= 1'b0;
`ifdef STRETCH_QUEUE_EN
      r_pending <= '0;
`endif
    end else begin
      r_inp_q <= inp;
      unique case (r_state)
        StIdle: begin
          if (w_ev) begin
            r_state <= StHold;
            r_count <= '0;
            r_out   <= 1'b1;
            r_busy  <= 1'b1;
          end
        end

        StHold: begin
`ifdef STRETCH_QUEUE_EN
          if (w_ev && !w_pend_full) begin
            r_pending <= r_pending + 1'b1;
          end
          if (r_count == HoldLast) begin
            r_state <= StGap;
            r_count <= '0;
            r_out   <= 1'b0;
          end else begin
            r_count <= r_count + 1'b1;
          end
`else
          // Retrigger: the pulse ends hold_cycles after the most recent event.
          if (w_ev) begin
            r_count <= '0;
          end else if (r_count == HoldLast) begin
            r_state <= StGap;
            r_count <= '0;
            r_out   <= 1'b0;
          end else begin
            r_count <= r_count + 1'b1;
          end
`endif
        end

        StGap: begin
          if (r_count == GapLast) begin
`ifdef STRETCH_QUEUE_EN
            // An event on the last gap cycle is consumed directly, so it does not
            // touch the pending count; otherwise one queued event is consumed.
            if ((r_pending != '0) || w_ev) begin
              r_state <= StHold;
              r_count <= '0;
              r_out   <= 1'b1;
              if (!w_ev) begin
                r_pending <= r_pending - 1'b1;
              end
            end else begin
              r_state <= StIdle;
              r_count <= '0;
              r_busy  <= 1'b0;
            end
`else
            r_state <= StIdle;
            r_count <= '0;
            r_busy  <= 1'b0;
`endif
          end else begin
            r_count <= r_count + 1'b1;
`ifdef STRETCH_QUEUE_EN
            if (w_ev && !w_pend_full) begin
              r_pending <= r_pending + 1'b1;
            end
`endif
          end
        end

        default: begin
          r_state <= StIdle;
          r_count <= '0;
          r_out   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign out  = r_out;
  assign busy = r_busy;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher with hold_cycles=4, gap_cycles=3, pend_width=2.
// A timeline model (pulse end times plus a pending count) is compared every cycle;
// directed patterns pin the model with hand-computed values.

module tb_pulse_stretcher;

  localparam int unsigned H    = 4;
  localparam int unsigned G    = 3;
  localparam int unsigned PW   = 2;
  localparam int          PMax = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          inp;
  logic          out;
  logic          busy;
  logic [PW-1:0] pending;

  pulse_stretcher #(
    .hold_cycles(H),
    .gap_cycles (G),
    .pend_width (PW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .inp    (inp),
    .out    (out),
    .busy   (busy),
    .pending(pending)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- timeline model ----------------
  // out is high for cycles < m_hold_end, busy for cycles < m_gap_end.
  int   cyc        = 0;
  int   m_hold_end = 0;
  int   m_gap_end  = 0;
  int   m_pend     = 0;
  logic m_inp_prev = 1'b0;
  logic m_ev;

  always @(negedge clk) begin
    if (rst) begin
      m_hold_end = cyc;
      m_gap_end  = cyc;
      m_pend     = 0;
      m_inp_prev = 1'b0;
    end else begin
      check("model_out", out, (cyc < m_hold_end));
      check("model_busy", busy, (cyc < m_gap_end));
      check("model_pending", pending, m_pend);
      m_ev       = inp && !m_inp_prev;
      m_inp_prev = inp;
      if (cyc >= m_gap_end) begin
        if (m_ev) begin
          m_hold_end = cyc + 1 + H;
          m_gap_end  = m_hold_end + G;
        end
      end
`ifdef STRETCH_QUEUE_EN
      else if (cyc == m_gap_end - 1) begin
        if (m_pend > 0 || m_ev) begin
          m_pend     = m_pend + int'(m_ev) - 1;
          if (m_pend > PMax) m_pend = PMax;
          m_hold_end = cyc + 1 + H;
          m_gap_end  = m_hold_end + G;
        end
      end else if (m_ev) begin
        m_pend = (m_pend < PMax) ? m_pend + 1 : PMax;
      end
`else
      else if (cyc < m_hold_end && m_ev) begin
        m_hold_end = cyc + 1 + H;
        m_gap_end  = m_hold_end + G;
      end
`endif
    end
    cyc++;
  end

  // ---------------- directed stimulus ----------------
  logic out_h  [64];
  logic busy_h [64];
  int   pend_h [64];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // inp = pat[i] during cycle i of the window; outputs of cycle i recorded at index i.
  task automatic run_pattern(input logic [63:0] pat, input int len);
    for (int i = 0; i < len; i++) begin
      inp       = pat[i];
      out_h[i]  = out;
      busy_h[i] = busy;
      pend_h[i] = int'(pending);
      tick();
    end
    inp = 1'b0;
    repeat (10) tick();
  endtask

  task automatic count_pulses(input int len, output int ones, output int rises);
    ones  = 0;
    rises = 0;
    for (int i = 0; i < len; i++) begin
      if (out_h[i]) ones++;
      if (out_h[i] && (i == 0 || !out_h[i-1])) rises++;
    end
  endtask

  int ones;
  int rises;

  initial begin
    rst = 1'b1;
    inp = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_out", out, 0);
    check("reset_busy", busy, 0);
    check("reset_pending", pending, 0);
    repeat (3) tick();

    // Reset asserted in the middle of the high phase clears outputs at once.
    inp = 1'b1;
    tick();
    inp = 1'b0;
    tick();
    check("pre_reset_out", out, 1);
    #2 rst = 1'b1;
    #1;
    check("async_reset_out", out, 0);
    check("async_reset_busy", busy, 0);
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("post_reset_out", out, 0);
      tick();
    end

    // Single-cycle event: high cycles 1..4, low 5..7, idle from 8.
    run_pattern(64'h1, 14);
    for (int i = 0; i < 14; i++) begin
      check("single_out", out_h[i], (i >= 1 && i <= 4));
      check("single_busy", busy_h[i], (i >= 1 && i <= 7));
    end

    // Level held high 50 cycles is one event.
    inp = 1'b1;
    for (int i = 0; i < 50; i++) begin
      out_h[i] = out;
      tick();
    end
    inp = 1'b0;
    repeat (10) tick();
    count_pulses(50, ones, rises);
    check("level_ones", ones, 4);
    check("level_rises", rises, 1);

`ifndef STRETCH_QUEUE_EN
    // Retrigger during high phase: edges at 0 and 3 -> high 1..7.
    run_pattern(64'b1001, 16);
    for (int i = 0; i < 16; i++) begin
      check("retrig_out", out_h[i], (i >= 1 && i <= 7));
    end
    check("retrig_busy_end", busy_h[10], 1);
    check("retrig_idle", busy_h[11], 0);

    // Edge in the middle of the gap is dropped.
    run_pattern(64'h41, 16);
    count_pulses(16, ones, rises);
    check("gap_drop_ones", ones, 4);
    check("gap_drop_idle", busy_h[8], 0);

    // Edge on the last gap cycle is dropped too.
    run_pattern(64'h81, 16);
    count_pulses(16, ones, rises);
    check("lastgap_drop_ones", ones, 4);
    check("lastgap_drop_pend", pend_h[8], 0);
`else
    // Edges at 0,2,4,6,8,10: pending saturates at 3, the edge at 10 is dropped.
    run_pattern(64'h555, 50);
    check("q_pend_3", pend_h[3], 1);
    check("q_pend_5", pend_h[5], 2);
    check("q_pend_7", pend_h[7], 3);
    check("q_pend_8", pend_h[8], 2);
    check("q_pend_9", pend_h[9], 3);
    check("q_pend_11", pend_h[11], 3);
    check("q_pend_15", pend_h[15], 2);
    check("q_pend_22", pend_h[22], 1);
    check("q_pend_29", pend_h[29], 0);
    check("q_busy_35", busy_h[35], 1);
    check("q_busy_36", busy_h[36], 0);
    count_pulses(50, ones, rises);
    check("q_ones", ones, 20);
    check("q_rises", rises, 5);

    // Edge on the last gap cycle with nothing pending: next pulse starts at once.
    run_pattern(64'h81, 20);
    check("q_lastgap_out8", out_h[8], 1);
    check("q_lastgap_pend8", pend_h[8], 0);
    check("q_lastgap_idle", busy_h[15], 0);
    count_pulses(20, ones, rises);
    check("q_lastgap_ones", ones, 8);
    check("q_lastgap_rises", rises, 2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
